// File: rtl/regfile_pkg.sv
// Shared constants and types for the writeback-staged register file.
package regfile_pkg;

    localparam int DATA_W   = 64;
    localparam int N_REGS   = 32;
    localparam int ADDR_W   = $clog2(N_REGS);
    localparam int ZERO_REG = 31;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_writeback_dec.sv
// One-hot commit-enable decoder: maps the staged address to a single write strobe.
module dec_5to32
    import regfile_pkg::*;
(
    input  reg_addr_t   addr,
    input  logic        en,
    output logic [31:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Register file whose writes are staged for one edge before committing; reads
// bypass the staged entry so a value is visible from the edge it was accepted.
module regfile_writeback
    import regfile_pkg::ZERO_REG;
#(
    parameter int DATA_W = 64,
    parameter int N_REGS = 32,
    localparam int ADDR_W = $clog2(N_REGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              pend_valid
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs [N_REGS];
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_data;
    logic [31:0]       commit_en;
    logic              wr_qualified;

    assign wr_qualified = wr_en && (wr_addr != ZERO_ADDR);

    dec_5to32 u_dec (
        .addr   (pend_addr),
        .en     (pend_valid),
        .onehot (commit_en)
    );

    // Staging register: a new qualifying write replaces the entry being committed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
        end else begin
            pend_valid <= wr_qualified;
            if (wr_qualified) begin
                pend_addr <= wr_addr;
                pend_data <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REGS; i++) begin
                if (commit_en[i]) begin
                    regs[i] <= pend_data;
                end
            end
        end
    end

    // The incoming wr_data is deliberately not forwarded; only the staged entry bypasses.
    always_comb begin
        if (rd_addr1 == ZERO_ADDR) begin
            rd_data1 = '0;
        end else if (pend_valid && (pend_addr == rd_addr1)) begin
            rd_data1 = pend_data;
        end else begin
            rd_data1 = regs[rd_addr1];
        end
    end

    always_comb begin
        if (rd_addr2 == ZERO_ADDR) begin
            rd_data2 = '0;
        end else if (pend_valid && (pend_addr == rd_addr2)) begin
            rd_data2 = pend_data;
        end else begin
            rd_data2 = regs[rd_addr2];
        end
    end

endmodule
